ibex_trace_buffer: RTL and testbench
====================================

Name: ibex_trace_buffer

Overview:
- Captures per-instruction retirement records from the core's RVFI outputs into a parametrised on-chip buffer.
- Drains records over a valid/ready stream, for a debug or trace-port consumer.
- Two modes:
  - continuous FIFO with a drop counter;
  - trap-triggered ring buffer that keeps pre-trigger history, captures a fixed post-trigger window, then freezes.
- Sits beside the core in the tracing top level, in parallel with the simulation tracer.

Parameters:
- Depth, 16, number of record entries; power of 2, ≥2.
- PostTrigCnt, 8, records stored after and including the trigger record; must be < Depth.
- DropCntWidth, 16, width of the saturating drop counter.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, synchronous, active-high.
- mode_i  in  2  00 off, 01 continuous, 10 trap-trigger, 11 reserved (treated as off).
- clear_i  in  1  flush buffer and counters; re-evaluate mode_i.
- rvfi_valid  in  1  retirement strobe.
- rvfi_trap  in  1  trap flag.
- rvfi_intr  in  1  interrupt flag.
- rvfi_rd_addr  in  5  destination register.
- rvfi_pc_rdata  in  32  PC.
- rvfi_insn  in  32  instruction word.
- rvfi_rd_wdata  in  32  writeback data.
- rvfi_mem_addr  in  32  memory address (used only with TRACE_MEM_EN).
- rvfi_mem_rmask  in  4  read mask (used only with TRACE_MEM_EN).
- rvfi_mem_wmask  in  4  write mask (used only with TRACE_MEM_EN).
- trace_valid_o  out  1  record available.
- trace_ready_i  in  1  consumer accepts.
- trace_data_o  out  RecW  record {trap, intr, rd_addr, pc, insn, rd_wdata[, mem_addr, rmask, wmask]}; RecW = 103, or 143 with TRACE_MEM_EN.
- level_o  out  $clog2(Depth+1)  occupied entries.
- drop_cnt_o  out  DropCntWidth  records lost in continuous mode.
- triggered_o  out  1  trigger seen; high in POST and FROZEN.

Behaviour:
- Reset: all outputs 0, buffer empty, FSM in OFF. clear_i has the same effect as reset, except the FSM then goes to OFF, RUN or PRE according to mode_i.
- Clock and reset: one clock, clk_i; synchronous active-high reset, rst_i.
- mode_i is quasi-static:
  - it is sampled only in OFF or on clear_i;
  - changes at any other time are ignored until the next clear_i.
- FSM states: OFF, RUN, PRE, POST, FROZEN.
  - OFF: no stores; trace_valid_o=0. Moves to RUN if mode_i=01, or to PRE if mode_i=10.
  - RUN: stores each rvfi_valid record.
    - Drain enabled.
    - Full with no pop in that cycle: new record dropped; drop_cnt_o increments and saturates at all-ones.
    - Full with a pop in the same cycle: push accepted, no drop.
  - PRE: stores each record.
    - If full, the oldest entry is overwritten (read pointer advances; not counted as a drop).
    - Drain disabled (trace_valid_o=0).
    - rvfi_valid && rvfi_trap: record stored, post counter loaded to PostTrigCnt-1. Next state is POST, or FROZEN if PostTrigCnt ≤ 1.
  - POST: stores each record with overwrite-oldest.
    - Counter decrements per stored record; after the store with counter=0, moves to FROZEN.
    - Further traps are stored as ordinary records.
    - Drain disabled.
  - FROZEN: no stores. Drain enabled. Stays here when empty until clear_i.
- Latency: a record pushed in cycle N is visible on trace_valid_o/trace_data_o in cycle N+1. No combinational bypass.
- Handshake:
  - pop when trace_valid_o && trace_ready_i;
  - trace_data_o stable while trace_valid_o && !trace_ready_i;
  - trace_valid_o never drops without a pop, except on rst_i/clear_i.
- Pointers: log2(Depth)-bit wrap-around pointers. level_o ranges 0..Depth and is correct across wrap-around.
- Reset or clear mid-drain: the in-flight record is discarded; trace_valid_o=0 in the next cycle.

Optional Feature:
- TRACE_MEM_EN defined:
  - records append mem_addr, mem_rmask, mem_wmask;
  - RecW=143.
- Not defined:
  - those inputs are unused and no storage is allocated for them;
  - RecW=103.

Test Plan:
1. Continuous, Depth=16: push 5 records with trace_ready_i=1 → 5 pops in order, first trace_valid_o one cycle after the first push, level_o returns to 0.
2. Continuous: push 20 records with trace_ready_i=0 → level_o=16, drop_cnt_o=4; the drained records are the first 16.
3. Continuous, full: push and pop in the same cycle → level_o stays 16, drop_cnt_o unchanged.
4. Trigger, PostTrigCnt=8:
   - stimulus: 30 records, trap on record #20 (records #21..#27 also sent);
   - required: FROZEN after #27, triggered_o=1, level_o=16, drained sequence #12..#27, no trace_valid_o before FROZEN.
5. Trigger, PostTrigCnt=1: trap on the first record → immediate FROZEN, level_o=1, later records ignored.
6. Mid-drain: assert clear_i with level_o=7 and mode_i=01 → next cycle level_o=0, trace_valid_o=0, drop_cnt_o=0, FSM in RUN.

Source files
------------

// File: rtl/ibex_trace_buffer.sv
// RVFI retirement trace buffer: continuous FIFO with a drop counter, or a trap-triggered ring
// buffer that freezes after a post-trigger window. Macro TRACE_MEM_EN appends memory fields.

module ibex_trace_buffer #(
  parameter int unsigned Depth        = 16,
  parameter int unsigned PostTrigCnt  = 8,
  parameter int unsigned DropCntWidth = 16,
`ifdef TRACE_MEM_EN
  localparam int unsigned RecW        = 143,
`else
  localparam int unsigned RecW        = 103,
`endif
  localparam int unsigned LvlW        = $clog2(Depth + 1)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [1:0]              mode_i,
  input  logic                    clear_i,
  input  logic                    rvfi_valid,
  input  logic                    rvfi_trap,
  input  logic                    rvfi_intr,
  input  logic [4:0]              rvfi_rd_addr,
  input  logic [31:0]             rvfi_pc_rdata,
  input  logic [31:0]             rvfi_insn,
  input  logic [31:0]             rvfi_rd_wdata,
  input  logic [31:0]             rvfi_mem_addr,
  input  logic [3:0]              rvfi_mem_rmask,
  input  logic [3:0]              rvfi_mem_wmask,
  output logic                    trace_valid_o,
  input  logic                    trace_ready_i,
  output logic [RecW-1:0]         trace_data_o,
  output logic [LvlW-1:0]         level_o,
  output logic [DropCntWidth-1:0] drop_cnt_o,
  output logic                    triggered_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam logic [LvlW-1:0] LvlFull = LvlW'(Depth);
  localparam logic [PtrW-1:0] PostLoad = PtrW'(PostTrigCnt - 32'd1);
  localparam logic [DropCntWidth-1:0] DropMax = {DropCntWidth{1'b1}};

  typedef enum logic [2:0] {
    ST_OFF    = 3'd0,
    ST_RUN    = 3'd1,
    ST_PRE    = 3'd2,
    ST_POST   = 3'd3,
    ST_FROZEN = 3'd4
  } state_e;

  function automatic state_e mode_to_state(input logic [1:0] mode);
    state_e st;
    case (mode)
      2'b01:   st = ST_RUN;
      2'b10:   st = ST_PRE;
      default: st = ST_OFF;
    endcase
    return st;
  endfunction

  state_e                  state_r, state_s;
  logic [RecW-1:0]         mem_r [Depth];
  logic [PtrW-1:0]         wr_ptr_r, wr_ptr_s;
  logic [PtrW-1:0]         rd_ptr_r, rd_ptr_s;
  logic [LvlW-1:0]         level_r, level_s;
  logic [DropCntWidth-1:0] drop_cnt_r, drop_cnt_s;
  logic [PtrW-1:0]         post_cnt_r, post_cnt_s;
  logic                    triggered_r, triggered_s;
  logic                    valid_r, valid_s;
  logic                    push_s, pop_s, overwrite_s, drop_s, full_s;
  logic [RecW-1:0]         rec_s;

`ifdef TRACE_MEM_EN
  assign rec_s = {rvfi_trap, rvfi_intr, rvfi_rd_addr, rvfi_pc_rdata, rvfi_insn, rvfi_rd_wdata,
                  rvfi_mem_addr, rvfi_mem_rmask, rvfi_mem_wmask};
`else
  assign rec_s = {rvfi_trap, rvfi_intr, rvfi_rd_addr, rvfi_pc_rdata, rvfi_insn, rvfi_rd_wdata};
  logic unused_mem_s;
  assign unused_mem_s = ^{rvfi_mem_addr, rvfi_mem_rmask, rvfi_mem_wmask};
`endif

  assign full_s = (level_r == LvlFull);
  // valid_r is only ever set in RUN/FROZEN, so a pop never coincides with an overwrite
  assign pop_s  = valid_r & trace_ready_i;

  // Mode FSM: decides whether this cycle's record is stored, dropped or overwrites the oldest
  always_comb begin
    state_s     = state_r;
    push_s      = 1'b0;
    overwrite_s = 1'b0;
    drop_s      = 1'b0;
    post_cnt_s  = post_cnt_r;
    case (state_r)
      ST_OFF: begin
        state_s = mode_to_state(mode_i);
      end
      ST_RUN: begin
        if (rvfi_valid) begin
          if (!full_s || pop_s) begin
            push_s = 1'b1;
          end else begin
            drop_s = 1'b1;
          end
        end else begin
          push_s = 1'b0;
        end
      end
      ST_PRE: begin
        if (rvfi_valid) begin
          push_s      = 1'b1;
          overwrite_s = full_s;
          if (rvfi_trap) begin
            post_cnt_s = PostLoad;
            state_s    = (PostTrigCnt <= 32'd1) ? ST_FROZEN : ST_POST;
          end else begin
            post_cnt_s = post_cnt_r;
          end
        end else begin
          push_s = 1'b0;
        end
      end
      ST_POST: begin
        if (rvfi_valid) begin
          push_s      = 1'b1;
          overwrite_s = full_s;
          post_cnt_s  = post_cnt_r - PtrW'(1);
          if (post_cnt_r <= PtrW'(1)) begin
            state_s = ST_FROZEN;
          end else begin
            state_s = ST_POST;
          end
        end else begin
          push_s = 1'b0;
        end
      end
      ST_FROZEN: begin
        state_s = ST_FROZEN;
      end
      default: begin
        state_s = ST_OFF;
      end
    endcase
  end

  // Pointer, level, counter and output-flag next values
  always_comb begin
    if (push_s && !pop_s && !overwrite_s) begin
      level_s = level_r + LvlW'(1);
    end else if (pop_s && !push_s) begin
      level_s = level_r - LvlW'(1);
    end else begin
      level_s = level_r;
    end
    if (pop_s || overwrite_s) begin
      rd_ptr_s = rd_ptr_r + PtrW'(1);
    end else begin
      rd_ptr_s = rd_ptr_r;
    end
    if (push_s) begin
      wr_ptr_s = wr_ptr_r + PtrW'(1);
    end else begin
      wr_ptr_s = wr_ptr_r;
    end
    if (drop_s && (drop_cnt_r != DropMax)) begin
      drop_cnt_s = drop_cnt_r + DropCntWidth'(1);
    end else begin
      drop_cnt_s = drop_cnt_r;
    end
    triggered_s = (state_s == ST_POST) || (state_s == ST_FROZEN);
    valid_s     = ((state_s == ST_RUN) || (state_s == ST_FROZEN)) && (level_s != LvlW'(0));
  end

  // Control state; clear_i flushes like reset but re-reads mode_i
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r     <= ST_OFF;
      wr_ptr_r    <= PtrW'(0);
      rd_ptr_r    <= PtrW'(0);
      level_r     <= LvlW'(0);
      drop_cnt_r  <= DropCntWidth'(0);
      post_cnt_r  <= PtrW'(0);
      triggered_r <= 1'b0;
      valid_r     <= 1'b0;
    end else if (clear_i) begin
      state_r     <= mode_to_state(mode_i);
      wr_ptr_r    <= PtrW'(0);
      rd_ptr_r    <= PtrW'(0);
      level_r     <= LvlW'(0);
      drop_cnt_r  <= DropCntWidth'(0);
      post_cnt_r  <= PtrW'(0);
      triggered_r <= 1'b0;
      valid_r     <= 1'b0;
    end else begin
      state_r     <= state_s;
      wr_ptr_r    <= wr_ptr_s;
      rd_ptr_r    <= rd_ptr_s;
      level_r     <= level_s;
      drop_cnt_r  <= drop_cnt_s;
      post_cnt_r  <= post_cnt_s;
      triggered_r <= triggered_s;
      valid_r     <= valid_s;
    end
  end

  // Record storage
  always_ff @(posedge clk_i) begin
    if (push_s && !rst_i && !clear_i) begin
      mem_r[wr_ptr_r] <= rec_s;
    end
  end

  assign trace_valid_o = valid_r;
  assign trace_data_o  = valid_r ? mem_r[rd_ptr_r] : {RecW{1'b0}};
  assign level_o       = level_r;
  assign drop_cnt_o    = drop_cnt_r;
  assign triggered_o   = triggered_r;

endmodule

// File: tb/tb_ibex_trace_buffer.sv
// Self-checking bench for ibex_trace_buffer: vector table, directed corner sequences and a
// randomized run against a queue-based reference model.

module tb_ibex_trace_buffer;
`ifdef TRACE_MEM_EN
  localparam int RecW = 143;
`else
  localparam int RecW = 103;
`endif
  localparam int Depth = 16;
  localparam int PostTrig = 8;
  localparam int S_OFF = 0, S_RUN = 1, S_PRE = 2, S_POST = 3, S_FRZ = 4;

  logic clk, rst, clear, ready;
  logic [1:0] mode;
  logic rvfi_valid, rvfi_trap, rvfi_intr;
  logic [4:0] rvfi_rd_addr;
  logic [31:0] rvfi_pc_rdata, rvfi_insn, rvfi_rd_wdata, rvfi_mem_addr;
  logic [3:0] rvfi_mem_rmask, rvfi_mem_wmask;
  logic t_valid, t1_valid, t_trig, t1_trig;
  logic [RecW-1:0] t_data, t1_data;
  logic [4:0] t_level, t1_level;
  logic [15:0] t_drop, t1_drop;

  int checks = 0;
  int errors = 0;

  ibex_trace_buffer u_dut (
    .clk_i(clk), .rst_i(rst), .mode_i(mode), .clear_i(clear),
    .rvfi_valid(rvfi_valid), .rvfi_trap(rvfi_trap), .rvfi_intr(rvfi_intr),
    .rvfi_rd_addr(rvfi_rd_addr), .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_insn(rvfi_insn),
    .rvfi_rd_wdata(rvfi_rd_wdata), .rvfi_mem_addr(rvfi_mem_addr),
    .rvfi_mem_rmask(rvfi_mem_rmask), .rvfi_mem_wmask(rvfi_mem_wmask),
    .trace_valid_o(t_valid), .trace_ready_i(ready), .trace_data_o(t_data),
    .level_o(t_level), .drop_cnt_o(t_drop), .triggered_o(t_trig)
  );

  ibex_trace_buffer #(.PostTrigCnt(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .mode_i(mode), .clear_i(clear),
    .rvfi_valid(rvfi_valid), .rvfi_trap(rvfi_trap), .rvfi_intr(rvfi_intr),
    .rvfi_rd_addr(rvfi_rd_addr), .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_insn(rvfi_insn),
    .rvfi_rd_wdata(rvfi_rd_wdata), .rvfi_mem_addr(rvfi_mem_addr),
    .rvfi_mem_rmask(rvfi_mem_rmask), .rvfi_mem_wmask(rvfi_mem_wmask),
    .trace_valid_o(t1_valid), .trace_ready_i(ready), .trace_data_o(t1_data),
    .level_o(t1_level), .drop_cnt_o(t1_drop), .triggered_o(t1_trig)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [RecW-1:0] mk_rec(input logic trap, input logic intr,
                                             input logic [31:0] pc);
`ifdef TRACE_MEM_EN
    return {trap, intr, pc[4:0], pc, pc ^ 32'h5A5A_5A5A, pc + 32'd1,
            pc + 32'd4, pc[3:0], pc[7:4]};
`else
    return {trap, intr, pc[4:0], pc, pc ^ 32'h5A5A_5A5A, pc + 32'd1};
`endif
  endfunction

  task automatic set_rec(input logic v, input logic trap, input logic intr,
                         input logic [31:0] pc);
    rvfi_valid = v; rvfi_trap = trap; rvfi_intr = intr;
    rvfi_rd_addr = pc[4:0]; rvfi_pc_rdata = pc; rvfi_insn = pc ^ 32'h5A5A_5A5A;
    rvfi_rd_wdata = pc + 32'd1; rvfi_mem_addr = pc + 32'd4;
    rvfi_mem_rmask = pc[3:0]; rvfi_mem_wmask = pc[7:4];
  endtask

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear(input logic [1:0] m);
    clear = 1'b1; mode = m; set_rec(1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    clear = 1'b0;
  endtask

  // Reference model: spec rules over a queue
  logic [RecW-1:0] mq[$];
  int m_st, m_post, m_drop;

  function automatic int mstate(input logic [1:0] m);
    return (m == 2'b01) ? S_RUN : (m == 2'b10) ? S_PRE : S_OFF;
  endfunction

  function automatic logic m_valid();
    return ((m_st == S_RUN) || (m_st == S_FRZ)) && (mq.size() > 0);
  endfunction

  task automatic model_step(input logic r, input logic c, input logic [1:0] m, input logic v,
                            input logic trap, input logic [RecW-1:0] rec, input logic rdy);
    if (r || c) begin
      mq.delete(); m_drop = 0; m_st = r ? S_OFF : mstate(m);
    end else begin
      if (m_valid() && rdy) void'(mq.pop_front());
      case (m_st)
        S_OFF: m_st = mstate(m);
        S_RUN: if (v) begin
          if (mq.size() < Depth) mq.push_back(rec);
          else if (m_drop < 65535) m_drop++;
        end
        S_PRE, S_POST: if (v) begin
          mq.push_back(rec);
          if (mq.size() > Depth) void'(mq.pop_front());
          if (m_st == S_PRE) begin
            if (trap) begin
              m_post = PostTrig - 1;
              m_st = (m_post == 0) ? S_FRZ : S_POST;
            end
          end else begin
            m_post--;
            if (m_post == 0) m_st = S_FRZ;
          end
        end
        default: ;
      endcase
    end
  endtask

  typedef struct {
    logic clr; logic [1:0] md; logic v; logic rdy; logic [31:0] pc;
    logic exp_valid; logic [4:0] exp_level; logic [31:0] exp_pc;
  } vec_t;
  vec_t vecs[12];

  initial begin
    int early;
    logic r, c, v, tr, it, rdy;
    logic [1:0] m;
    logic [31:0] pc;

    vecs[0]  = '{1'b1, 2'b01, 1'b0, 1'b1, 32'h0,   1'b0, 5'd0, 32'h0};
    vecs[1]  = '{1'b0, 2'b01, 1'b1, 1'b1, 32'hA01, 1'b1, 5'd1, 32'hA01};
    vecs[2]  = '{1'b0, 2'b01, 1'b1, 1'b1, 32'hA02, 1'b1, 5'd1, 32'hA02};
    vecs[3]  = '{1'b0, 2'b01, 1'b1, 1'b1, 32'hA03, 1'b1, 5'd1, 32'hA03};
    vecs[4]  = '{1'b0, 2'b01, 1'b1, 1'b1, 32'hA04, 1'b1, 5'd1, 32'hA04};
    vecs[5]  = '{1'b0, 2'b01, 1'b1, 1'b1, 32'hA05, 1'b1, 5'd1, 32'hA05};
    vecs[6]  = '{1'b0, 2'b01, 1'b0, 1'b1, 32'h0,   1'b0, 5'd0, 32'h0};
    vecs[7]  = '{1'b0, 2'b01, 1'b1, 1'b0, 32'hB01, 1'b1, 5'd1, 32'hB01};
    vecs[8]  = '{1'b0, 2'b01, 1'b1, 1'b0, 32'hB02, 1'b1, 5'd2, 32'hB01};
    vecs[9]  = '{1'b0, 2'b01, 1'b0, 1'b0, 32'h0,   1'b1, 5'd2, 32'hB01};
    vecs[10] = '{1'b0, 2'b01, 1'b0, 1'b1, 32'h0,   1'b1, 5'd1, 32'hB02};
    vecs[11] = '{1'b0, 2'b01, 1'b0, 1'b1, 32'h0,   1'b0, 5'd0, 32'h0};

    // Reset
    rst = 1'b1; clear = 1'b0; mode = 2'b00; ready = 1'b0;
    set_rec(1'b0, 1'b0, 1'b0, 32'h0);
    tick(); tick();
    chk("rst_valid", t_valid, 0); chk("rst_level", t_level, 0); chk("rst_drop", t_drop, 0);
    chk("rst_trig", t_trig, 0); chk("rst_data", t_data, 0);
    rst = 1'b0;
    set_rec(1'b1, 1'b0, 1'b0, 32'h77);
    tick();
    set_rec(1'b0, 1'b0, 1'b0, 32'h0);
    chk("off_no_store", t_level, 0); chk("off_valid", t_valid, 0);

    // Vector table: continuous mode basic flow and back-pressure
    foreach (vecs[i]) begin
      clear = vecs[i].clr; mode = vecs[i].md; ready = vecs[i].rdy;
      set_rec(vecs[i].v, 1'b0, 1'b0, vecs[i].pc);
      tick();
      chk($sformatf("vec%0d_valid", i), t_valid, vecs[i].exp_valid);
      chk($sformatf("vec%0d_level", i), t_level, vecs[i].exp_level);
      if (vecs[i].exp_valid)
        chk($sformatf("vec%0d_data", i), t_data, mk_rec(1'b0, 1'b0, vecs[i].exp_pc));
    end
    clear = 1'b0;
    chk("vec_drop", t_drop, 0);

    // Overflow with drops, then push+pop while full
    do_clear(2'b01);
    ready = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      set_rec(1'b1, 1'b0, 1'b0, 32'h1000 + i);
      tick();
    end
    set_rec(1'b0, 1'b0, 1'b0, 32'h0);
    chk("ovf_level", t_level, 16); chk("ovf_drop", t_drop, 4);
    chk("ovf_head", t_data, mk_rec(1'b0, 1'b0, 32'h1001));
    ready = 1'b1;
    set_rec(1'b1, 1'b0, 1'b0, 32'h2000);
    tick();
    set_rec(1'b0, 1'b0, 1'b0, 32'h0);
    chk("fullpp_level", t_level, 16); chk("fullpp_drop", t_drop, 4);
    for (int k = 2; k <= 16; k++) begin
      chk($sformatf("ovf_drain%0d", k), t_data, mk_rec(1'b0, 1'b0, 32'h1000 + k));
      tick();
    end
    chk("ovf_drain_last", t_data, mk_rec(1'b0, 1'b0, 32'h2000));
    tick();
    chk("ovf_empty_level", t_level, 0); chk("ovf_empty_valid", t_valid, 0);

    // Trap trigger, PostTrigCnt=8
    do_clear(2'b10);
    ready = 1'b0; early = 0;
    for (int i = 1; i <= 30; i++) begin
      set_rec(1'b1, (i == 20), 1'b0, 32'h3000 + i);
      tick();
      if (i < 27 && t_valid) early++;
      if (i == 19) chk("trig_before", t_trig, 0);
      if (i == 20) chk("trig_after", t_trig, 1);
    end
    set_rec(1'b0, 1'b0, 1'b0, 32'h0);
    chk("trig_early_valid", early, 0);
    chk("trig_level", t_level, 16); chk("trig_valid", t_valid, 1); chk("trig_flag", t_trig, 1);
    ready = 1'b1;
    for (int k = 12; k <= 27; k++) begin
      chk($sformatf("trig_drain%0d", k), t_data, mk_rec(k == 20, 1'b0, 32'h3000 + k));
      tick();
    end
    chk("trig_empty", t_valid, 0); chk("trig_frozen_flag", t_trig, 1);

    // PostTrigCnt=1: trap on first record freezes at once
    do_clear(2'b10);
    ready = 1'b0;
    set_rec(1'b1, 1'b1, 1'b0, 32'h4001);
    tick();
    chk("pt1_trig", t1_trig, 1); chk("pt1_level", t1_level, 1); chk("pt1_valid", t1_valid, 1);
    for (int i = 2; i <= 4; i++) begin
      set_rec(1'b1, i[0], 1'b0, 32'h4000 + i);
      tick();
    end
    set_rec(1'b0, 1'b0, 1'b0, 32'h0);
    chk("pt1_ignored", t1_level, 1); chk("pt1_data", t1_data, mk_rec(1'b1, 1'b0, 32'h4001));
    chk("pt1_drop", t1_drop, 0);
    ready = 1'b1;
    tick();
    chk("pt1_drained", t1_valid, 0); chk("pt1_still_trig", t1_trig, 1);

    // Clear mid-drain with level 7
    do_clear(2'b01);
    ready = 1'b0;
    for (int i = 1; i <= 18; i++) begin
      set_rec(1'b1, 1'b0, 1'b0, 32'h5000 + i);
      tick();
    end
    set_rec(1'b0, 1'b0, 1'b0, 32'h0);
    ready = 1'b1;
    for (int i = 0; i < 9; i++) tick();
    chk("mid_level", t_level, 7); chk("mid_drop", t_drop, 2);
    clear = 1'b1; mode = 2'b01;
    tick();
    clear = 1'b0; ready = 1'b0;
    chk("clr_level", t_level, 0); chk("clr_valid", t_valid, 0); chk("clr_drop", t_drop, 0);
    set_rec(1'b1, 1'b0, 1'b0, 32'h6000);
    tick();
    set_rec(1'b0, 1'b0, 1'b0, 32'h0);
    chk("clr_run_valid", t_valid, 1); chk("clr_run_data", t_data, mk_rec(1'b0, 1'b0, 32'h6000));

    // Randomized run against the reference model
    rst = 1'b1; tick(); rst = 1'b0;
    mq.delete(); m_drop = 0; m_st = S_OFF; m_post = 0;
    for (int n = 0; n < 1500; n++) begin
      r = ($urandom_range(0, 299) == 0);
      c = ($urandom_range(0, 59) == 0);
      m = 2'($urandom_range(0, 3));
      v = 1'($urandom_range(0, 1));
      tr = ($urandom_range(0, 15) == 0);
      it = 1'($urandom_range(0, 1));
      pc = $urandom;
      rdy = ($urandom_range(0, 3) == 0);
      rst = r; clear = c; mode = m; ready = rdy;
      set_rec(v, tr, it, pc);
      model_step(r, c, m, v, tr, mk_rec(tr, it, pc), rdy);
      tick();
      chk("rnd_level", t_level, mq.size());
      chk("rnd_valid", t_valid, m_valid());
      chk("rnd_drop", t_drop, m_drop);
      chk("rnd_trig", t_trig, (m_st == S_POST) || (m_st == S_FRZ));
      if (m_valid()) chk("rnd_data", t_data, mq[0]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
